// File: rtl/kyber_bf_addsub.sv
// Kyber NTT butterfly add/sub: two-stage modular add/sub feeding an output FIFO with count-based backpressure.
// Optional KYBER_BF_HALVE_EN: inverse-pass entries (inv=1) are also multiplied by 2^-1 mod Q.
module kyber_bf_addsub #(
  parameter int W          = 12,
  parameter int Q          = 3329,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_t,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [W-1:0] out_diff
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [W:0]    Q_W1    = (W+1)'(Q);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic          accept;
  logic          pop;
  logic          s1_valid_reg;
  logic          s1_inv_reg;
  logic [W:0]    s1_sum_reg;
  logic [W:0]    s1_diff_reg;
  logic [W-1:0]  sum_corr;
  logic [W-1:0]  diff_corr;
  logic [W-1:0]  sum_fin;
  logic [W-1:0]  diff_fin;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [W-1:0]  mem_sum  [FIFO_DEPTH];
  logic [W-1:0]  mem_diff [FIFO_DEPTH];

  // x * 2^-1 mod Q: add Q to odd values so the shift is exact
  function automatic logic [W-1:0] halve(input logic [W-1:0] x);
    logic [W:0] t;
    t = x[0] ? ({1'b0, x} + Q_W1) : {1'b0, x};
    return W'(t >> 1);
  endfunction

  assign accept    = in_valid && in_ready;
  assign out_valid = (wr_ptr_reg != rd_ptr_reg);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count_reg < DEPTH_C);

  // Stage 1: raw sum (unsigned) and raw diff (two's complement), both W+1 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sum_reg  <= {1'b0, in_a} + {1'b0, in_t};
      s1_diff_reg <= {1'b0, in_a} - {1'b0, in_t};
      s1_inv_reg  <= in_inv;
    end
  end

  // Stage 2 correction; the FIFO slot itself is the stage-2 register
  always_comb begin
    sum_corr  = W'((s1_sum_reg >= Q_W1) ? (s1_sum_reg - Q_W1) : s1_sum_reg);
    diff_corr = W'(s1_diff_reg[W] ? (s1_diff_reg + Q_W1) : s1_diff_reg);
`ifdef KYBER_BF_HALVE_EN
    sum_fin   = s1_inv_reg ? halve(sum_corr)  : sum_corr;
    diff_fin  = s1_inv_reg ? halve(diff_corr) : diff_corr;
`else
    // inv still travels with the entry but selects identical values here
    sum_fin   = s1_inv_reg ? sum_corr  : sum_corr;
    diff_fin  = s1_inv_reg ? diff_corr : diff_corr;
`endif
  end

  always_ff @(posedge clk) begin
    if (s1_valid_reg) begin
      mem_sum[wr_ptr_reg[AW-1:0]]  <= sum_fin;
      mem_diff[wr_ptr_reg[AW-1:0]] <= diff_fin;
    end
  end

  // Count covers stage 1 plus FIFO entries, so a write never finds the FIFO full
  always_comb begin
    count_next = count_reg;
    case ({accept, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (s1_valid_reg) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)          rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign out_sum  = out_valid ? mem_sum[rd_ptr_reg[AW-1:0]]  : '0;
  assign out_diff = out_valid ? mem_diff[rd_ptr_reg[AW-1:0]] : '0;

endmodule

// File: tb/tb_kyber_bf_addsub.sv
// Directed and randomized-stream bench for kyber_bf_addsub with immediate-assertion checks.
module tb_kyber_bf_addsub;

  localparam int QM = 3329;
`ifdef KYBER_BF_HALVE_EN
  localparam bit HALVE = 1'b1;
`else
  localparam bit HALVE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_t;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [11:0] out_diff;

  int errors = 0;
  int checks = 0;

  kyber_bf_addsub #(.W(12), .Q(3329), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_t      (in_t),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_diff  (out_diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int half_q(input int x);
    return (x % 2 != 0) ? (x + QM) / 2 : x / 2;
  endfunction

  function automatic int ref_sum(input int a, input int t, input int inv);
    int x;
    x = (a + t) % QM;
    if (HALVE && inv != 0) x = half_q(x);
    return x;
  endfunction

  function automatic int ref_diff(input int a, input int t, input int inv);
    int x;
    x = (a - t + QM) % QM;
    if (HALVE && inv != 0) x = half_q(x);
    return x;
  endfunction

  // One isolated transfer with out_ready=1: checks acceptance, 2-cycle latency, result and pop
  task automatic send_one(input string tag, input int a, input int t, input int inv,
                          input int es, input int ed);
    in_valid = 1'b1;
    in_a     = 12'(a);
    in_t     = 12'(t);
    in_inv   = inv[0];
    chk({tag, ".ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".lat1"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    chk({tag, ".lat2"}, 32'(out_valid), 1);
    chk({tag, ".sum"},  32'(out_sum),   32'(es));
    chk({tag, ".diff"}, 32'(out_diff),  32'(ed));
    @(posedge clk); #1;
    chk({tag, ".popped"}, 32'(out_valid), 0);
    $display("txn %s a=%0d t=%0d inv=%0d sum=%0d diff=%0d", tag, a, t, inv, es, ed);
  endtask

  initial begin
    int bp_a [4] = '{3000, 3050, 3100, 3150};
    int bp_t [4] = '{200, 600, 1000, 1400};
    int bp_s [4] = '{3200, 321, 771, 1221};
    int bp_d [4] = '{2800, 2450, 2100, 1750};
    int acc;
    bit ir;
    int sent, got, cyc, ra, rt, ri;
    int qs[$];
    int qd[$];
    bit stale;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_t = '0; in_inv = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_sum",   32'(out_sum),   0);
    chk("rst.out_diff",  32'(out_diff),  0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst.in_ready", 32'(in_ready), 1);

    send_one("v3000_1000", 3000, 1000, 0, 671, 2000);
    send_one("v5_10",      5,    10,   0, 15, 3324);
    send_one("v3328_3328", 3328, 3328, 0, 3327, 0);
    send_one("v0_0",       0,    0,    0, 0, 0);
    send_one("v0_3328",    0,    3328, 0, 3328, 1);
    send_one("v1_0_inv0",  1,    0,    0, 1, 1);
    send_one("v1_0_inv1",  1,    0,    1, HALVE ? 1665 : 1, HALVE ? 1665 : 1);
    send_one("v4_2_inv1",  4,    2,    1, HALVE ? 3 : 6, HALVE ? 1 : 2);

    // Backpressure: out_ready low, in_valid held; exactly FIFO_DEPTH accepts
    out_ready = 1'b0;
    in_inv    = 1'b0;
    acc       = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_a     = 12'(bp_a[acc < 4 ? acc : 3]);
      in_t     = 12'(bp_t[acc < 4 ? acc : 3]);
      ir       = in_ready;
      @(posedge clk); #1;
      if (ir) acc++;
    end
    in_valid = 1'b0;
    chk("bp.accepts",  32'(acc), 4);
    chk("bp.in_ready", 32'(in_ready), 0);
    chk("bp.hold_valid", 32'(out_valid), 1);
    chk("bp.hold_sum",   32'(out_sum),   32'(bp_s[0]));
    $display("txn backpressure accepts=%0d", acc);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("bp.valid%0d", j), 32'(out_valid), 1);
      chk($sformatf("bp.sum%0d", j),   32'(out_sum),   32'(bp_s[j]));
      chk($sformatf("bp.diff%0d", j),  32'(out_diff),  32'(bp_d[j]));
      if (j == 1) chk("bp.ready_after_pop", 32'(in_ready), 1);
      $display("txn drain %0d sum=%0d diff=%0d", j, out_sum, out_diff);
      @(posedge clk); #1;
    end
    chk("bp.drained", 32'(out_valid), 0);

    // Random stream with random out_ready against the reference model
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      ra = int'($urandom_range(0, QM - 1));
      rt = int'($urandom_range(0, QM - 1));
      ri = int'($urandom_range(0, 1));
      in_a = 12'(ra); in_t = 12'(rt); in_inv = ri[0];
      if (out_valid && out_ready) begin
        if (qs.size() == 0) begin
          chk("rnd.extra_output", 1, 0);
        end else begin
          chk("rnd.sum",  32'(out_sum),  32'(qs.pop_front()));
          chk("rnd.diff", 32'(out_diff), 32'(qd.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        qs.push_back(ref_sum(ra, rt, ri));
        qd.push_back(ref_diff(ra, rt, ri));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd.received", 32'(got), 1000);
    chk("rnd.leftover", 32'(qs.size()), 0);
    $display("txn random sent=%0d got=%0d cycles=%0d", sent, got, cyc);

    // Reset with three entries in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = 12'(100 + k); in_t = 12'(50);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight.valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("inflight.rst_valid", 32'(out_valid), 0);
    chk("inflight.rst_sum",   32'(out_sum),   0);
    chk("inflight.rst_diff",  32'(out_diff),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("inflight.in_ready", 32'(in_ready), 1);
    stale = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      stale = stale | out_valid;
    end
    chk("inflight.no_stale", 32'(stale), 0);
    $display("txn reset_in_flight stale=%0d", stale);
    send_one("post_reset", 2000, 2500, 0, 1171, 2829);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kyber_bf_addsub.md
KYBER_BF_ADDSUB -- requirements
Module: kyber_bf_addsub

Interface
REQ-001 SHALL have parameter: W, 12, coefficient width.
REQ-002 SHALL have parameter: Q, 3329, Kyber modulus.
REQ-003 SHALL have parameter: FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: in_valid  input  1  operand pair present.
REQ-007 SHALL have port: in_ready  output  1  block accepts operand pair this cycle.
REQ-008 SHALL have port: in_a  input  W  butterfly top operand, range [0,Q-1].
REQ-009 SHALL have port: in_t  input  W  reduced product w*b mod q from the modular multiplier, range [0,Q-1].
REQ-010 SHALL have port: in_inv  input  1  inverse-NTT pass flag, travels with the data.
REQ-011 SHALL have ports: out_valid output 1, out_ready input 1, out_sum output W, out_diff output W.

Function
REQ-012 SHALL accept a transfer when in_valid && in_ready on a rising edge; SHALL ignore in_a/in_t/in_inv otherwise.
REQ-013 SHALL compute out_sum = (in_a + in_t) mod Q and out_diff = (in_a - in_t) mod Q, both in [0,Q-1].
REQ-014 Stage 1 SHALL register raw sum (W+1 bits, unsigned) and raw diff (W+1 bits, two's complement), plus valid and inv.
REQ-015 Stage 2 SHALL register corrected values: sum>=Q -> sum-Q; diff<0 -> diff+Q; plus valid and inv.
REQ-016 Stage 2 results SHALL enter the output FIFO unconditionally; the pipeline SHALL never stall.
REQ-017 Latency SHALL be 2 cycles from accepted input to out_valid with FIFO empty and out_ready=1.
REQ-018 SHALL keep an occupancy count = FIFO entries + valid pipeline stages; in_ready SHALL be 1 iff count < FIFO_DEPTH.
REQ-019 in_ready SHALL be a registered or count-only function and SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 iff FIFO non-empty; out_sum/out_diff SHALL show head entry and SHALL remain stable while out_valid && !out_ready.
REQ-021 Pop SHALL occur on out_valid && out_ready; simultaneous accept and pop SHALL leave count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; no overflow SHALL be possible by REQ-018.
REQ-023 Order SHALL be preserved: outputs leave in acceptance order.

Reset
REQ-024 On rst_n low: pipeline valids, FIFO pointers and count SHALL clear immediately; out_valid=0, out_sum=0, out_diff=0.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n deasserts; in-flight data at reset assertion SHALL be discarded.

Configuration
REQ-026 Macro KYBER_BF_HALVE_EN: when defined, Stage 2 SHALL additionally, for entries with inv=1, replace each result x by x/2 if x even, else (x+Q)/2 (i.e. x*2^-1 mod Q); latency unchanged.
REQ-027 Without KYBER_BF_HALVE_EN, in_inv SHALL be accepted but SHALL have no effect on results.

Verification
REQ-028 in_a=3000, in_t=1000, inv=0 -> out_sum=671, out_diff=2000, out_valid 2 cycles after accept.
REQ-029 in_a=5, in_t=10 -> out_sum=15, out_diff=3324; in_a=3328, in_t=3328 -> out_sum=3327, out_diff=0.
REQ-030 KYBER_BF_HALVE_EN defined, in_a=1, in_t=0, inv=1 -> out_sum=1665, out_diff=1665; same with inv=0 -> 1, 1.
REQ-031 out_ready=0, in_valid held 1 -> exactly 4 accepts then in_ready=0; raise out_ready -> 4 outputs in order, in_ready returns 1 the cycle after the first pop.
REQ-032 Streaming 1000 random pairs with out_ready toggled randomly -> every output matches reference model, no loss, no duplication.
REQ-033 Assert rst_n low with 3 entries in flight -> out_valid=0 immediately; after release, no stale entry appears.
